// File: rtl/addr_router_fsm_pkg.sv
// addr_router_fsm_pkg: shared FSM state and request-type encodings for bus control blocks
package addr_router_fsm_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE, ST_ERR} state_e;
   typedef enum logic [1:0] {REQ_NONE, REQ_WRITE, REQ_READ, REQ_BOTH} req_e;
   function automatic req_e decode_req(input logic w, input logic r);
      return (w && r) ? REQ_BOTH : w ? REQ_WRITE : r ? REQ_READ : REQ_NONE;
   endfunction
endpackage

// File: rtl/addr_router_fsm_timeout_cnt.sv
// bus_timeout_cnt: saturating cycle counter; expired_o flags the LIMIT-th enabled cycle
module bus_timeout_cnt #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = LIMIT > 0 ? $clog2(LIMIT + 1) : 1;
   logic [CW-1:0] cnt_q;
   always_ff @(posedge clk) begin
      if (rst || clr_i) cnt_q <= '0;
      else if (en_i && cnt_q != CW'(LIMIT)) cnt_q <= cnt_q + CW'(1);
   end
   // Flags during the final allowed cycle so the abort lands exactly LIMIT cycles after entry
   assign expired_o = (LIMIT != 0) && en_i && (cnt_q == CW'(LIMIT - 1));
endmodule

// File: rtl/addr_router_fsm.sv
// addr_router_fsm: latches one master request and holds a one-hot strobe to the addressed slave until done/err
module addr_router_fsm
   import addr_router_fsm_pkg::*;
#(
   parameter int ADDR_WIDTH       = 16,
   parameter int DEVICE_BIT_WIDTH = 2,
   parameter int NUM_SLAVES       = 3,
   parameter int TIMEOUT          = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_WIDTH-1:0]       addr,
   input  logic                        wen,
   input  logic                        ren,
   input  logic [NUM_SLAVES-1:0]       slave_done,
   output logic [NUM_SLAVES-1:0]       wen_o,
   output logic [NUM_SLAVES-1:0]       ren_o,
   output logic [DEVICE_BIT_WIDTH-1:0] read_mux_sel,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);
   state_e                        state_q;
   req_e                          req;
   logic [DEVICE_BIT_WIDTH-1:0]   dev_id;
   logic [NUM_SLAVES-1:0]         sel_oh;
   logic                          mapped, slave_hit, expired;
   logic                          unused_addr;
   assign dev_id      = addr[ADDR_WIDTH-1 -: DEVICE_BIT_WIDTH];
   assign unused_addr = ^addr[ADDR_WIDTH-DEVICE_BIT_WIDTH-1:0];
   assign req         = decode_req(wen, ren);
   assign mapped      = int'(dev_id) < NUM_SLAVES;
   assign sel_oh      = NUM_SLAVES'(1) << dev_id;
   // The live strobe is one-hot on the latched ID, so masking with it honours only that slave
   assign slave_hit   = |(slave_done & (wen_o | ren_o));
   bus_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (state_q == ST_IDLE),
      .en_i     (state_q == ST_ACTIVE),
      .expired_o(expired)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         wen_o        <= '0;
         ren_o        <= '0;
         read_mux_sel <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_q)
            ST_IDLE: if (req != REQ_NONE) begin
               read_mux_sel <= dev_id;
               busy         <= 1'b1;
               state_q      <= (req == REQ_BOTH || !mapped) ? ST_ERR : ST_ACTIVE;
               wen_o        <= (req == REQ_WRITE && mapped) ? sel_oh : '0;
               ren_o        <= (req == REQ_READ && mapped) ? sel_oh : '0;
            end
            ST_ACTIVE: if (slave_hit || expired) begin
               state_q <= slave_hit ? ST_DONE : ST_ERR;
               wen_o   <= '0;
               ren_o   <= '0;
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
               err     <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_addr_router_fsm.sv
// tb_addr_router_fsm: directed scenario tasks with hand-computed expectations for addr_router_fsm
module tb_addr_router_fsm;
   logic        clk = 1'b0;
   logic        rst, wen, ren;
   logic [15:0] addr;
   logic [2:0]  slave_done, wen_o, ren_o;
   logic [1:0]  read_mux_sel;
   logic        busy, done, err;
   int          checks = 0;
   int          errors = 0;

   addr_router_fsm #(.ADDR_WIDTH(16), .DEVICE_BIT_WIDTH(2), .NUM_SLAVES(3), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wen(wen), .ren(ren), .slave_done(slave_done),
      .wen_o(wen_o), .ren_o(ren_o), .read_mux_sel(read_mux_sel), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; slave_done = '0;
      tick(); tick();
      checks++; if ({wen_o, ren_o, read_mux_sel, busy, done, err} !== 11'd0) begin errors++; $display("FAIL reset_outputs got %b exp 0", {wen_o, ren_o, read_mux_sel, busy, done, err}); end
      rst = 1'b0;
      tick();
      checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_idle got %b exp 000", {busy, done, err}); end
   endtask

   task automatic test_write_id1();
      addr = 16'h4000; wen = 1'b1;
      tick();
      checks++; if (wen_o !== 3'b010 || ren_o !== 3'b000) begin errors++; $display("FAIL wr_strobe got %b/%b exp 010/000", wen_o, ren_o); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b exp 1", busy); end
      wen = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (wen_o !== 3'b010 || done !== 1'b0) begin errors++; $display("FAIL wr_hold got %b done %b exp 010 done 0", wen_o, done); end
      slave_done = 3'b010;
      tick();
      checks++; if (wen_o !== 3'b000 || done !== 1'b0) begin errors++; $display("FAIL wr_clear got %b done %b exp 000 done 0", wen_o, done); end
      slave_done = 3'b000;
      tick();
      checks++; if ({done, err, busy} !== 3'b100) begin errors++; $display("FAIL wr_done got %b exp 100", {done, err, busy}); end
      checks++; if (read_mux_sel !== 2'd1) begin errors++; $display("FAIL wr_sel got %0d exp 1", read_mux_sel); end
      tick();
      checks++; if (done !== 1'b0 || read_mux_sel !== 2'd1) begin errors++; $display("FAIL wr_after got done %b sel %0d exp 0 1", done, read_mux_sel); end
   endtask

   task automatic test_read_wrong_slave();
      addr = 16'h8000; ren = 1'b1;
      tick();
      checks++; if (ren_o !== 3'b100 || wen_o !== 3'b000) begin errors++; $display("FAIL rd_strobe got %b/%b exp 100/000", ren_o, wen_o); end
      ren = 1'b0; slave_done = 3'b001;
      tick();
      checks++; if (ren_o !== 3'b100 || busy !== 1'b1) begin errors++; $display("FAIL rd_ignore got %b busy %b exp 100 1", ren_o, busy); end
      slave_done = 3'b100;
      tick();
      checks++; if (ren_o !== 3'b000) begin errors++; $display("FAIL rd_clear got %b exp 000", ren_o); end
      slave_done = 3'b000;
      tick();
      checks++; if ({done, err} !== 2'b10 || read_mux_sel !== 2'd2) begin errors++; $display("FAIL rd_done got %b sel %0d exp 10 2", {done, err}, read_mux_sel); end
      tick();
   endtask

   task automatic test_unmapped();
      addr = 16'hC000; wen = 1'b1;
      tick();
      checks++; if (wen_o !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL um_err_state got %b busy %b done %b exp 000 1 0", wen_o, busy, done); end
      wen = 1'b0;
      tick();
      checks++; if ({done, err, busy} !== 3'b110 || wen_o !== 3'b000) begin errors++; $display("FAIL um_pulse got %b strobe %b exp 110 000", {done, err, busy}, wen_o); end
      checks++; if (read_mux_sel !== 2'd3) begin errors++; $display("FAIL um_sel got %0d exp 3", read_mux_sel); end
      tick();
      checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL um_single got %b exp 00", {done, err}); end
   endtask

   task automatic test_illegal_and_busy();
      addr = 16'h0000; wen = 1'b1; ren = 1'b1;
      tick();
      checks++; if (wen_o !== 3'b000 || ren_o !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL both_nostrobe got %b/%b busy %b exp 000/000 1", wen_o, ren_o, busy); end
      wen = 1'b0; ren = 1'b0;
      tick();
      checks++; if ({done, err} !== 2'b11 || read_mux_sel !== 2'd0) begin errors++; $display("FAIL both_pulse got %b sel %0d exp 11 0", {done, err}, read_mux_sel); end
      wen = 1'b1;
      tick();
      checks++; if (wen_o !== 3'b001) begin errors++; $display("FAIL busy_first got %b exp 001", wen_o); end
      wen = 1'b0; ren = 1'b1; addr = 16'h8000;
      tick();
      checks++; if (wen_o !== 3'b001 || ren_o !== 3'b000 || read_mux_sel !== 2'd0) begin errors++; $display("FAIL busy_ignored got %b/%b sel %0d exp 001/000 0", wen_o, ren_o, read_mux_sel); end
      ren = 1'b0; slave_done = 3'b001;
      tick();
      slave_done = 3'b000;
      tick();
      checks++; if ({done, err} !== 2'b10 || read_mux_sel !== 2'd0) begin errors++; $display("FAIL busy_done got %b sel %0d exp 10 0", {done, err}, read_mux_sel); end
      tick();
   endtask

   task automatic test_timeout();
      addr = 16'h4000; ren = 1'b1;
      tick();
      ren = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      checks++; if (ren_o !== 3'b010) begin errors++; $display("FAIL to_eighth got %b exp 010", ren_o); end
      tick();
      checks++; if (ren_o !== 3'b000 || done !== 1'b0) begin errors++; $display("FAIL to_abort got %b done %b exp 000 0", ren_o, done); end
      tick();
      checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL to_pulse got %b exp 11", {done, err}); end
      tick();
      addr = 16'h4000; ren = 1'b1;
      tick();
      ren = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      slave_done = 3'b010;
      tick();
      slave_done = 3'b000;
      checks++; if (ren_o !== 3'b000) begin errors++; $display("FAIL to_race_clear got %b exp 000", ren_o); end
      tick();
      checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL to_race_win got %b exp 10", {done, err}); end
      tick();
   endtask

   task automatic test_mid_reset();
      addr = 16'h4000; wen = 1'b1;
      tick();
      wen = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      checks++; if ({wen_o, ren_o, read_mux_sel, busy, done, err} !== 11'd0) begin errors++; $display("FAIL mr_drop got %b exp 0", {wen_o, ren_o, read_mux_sel, busy, done, err}); end
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL mr_nopulse got %b exp 000", {busy, done, err}); end
      addr = 16'h0000; wen = 1'b1;
      tick();
      wen = 1'b0;
      checks++; if (wen_o !== 3'b001) begin errors++; $display("FAIL mr_idle got %b exp 001", wen_o); end
      slave_done = 3'b001;
      tick();
      slave_done = 3'b000;
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      addr = 16'h0000; wen = 1'b1;
      tick();
      wen = 1'b0; slave_done = 3'b001;
      tick();
      slave_done = 3'b000;
      checks++; if (wen_o !== 3'b000 || done !== 1'b0) begin errors++; $display("FAIL b2b_clear got %b done %b exp 000 0", wen_o, done); end
      tick();
      checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL b2b_done got %b exp 10", {done, busy}); end
      addr = 16'h8000; ren = 1'b1;
      tick();
      ren = 1'b0;
      checks++; if (ren_o !== 3'b100 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept got %b done %b exp 100 0", ren_o, done); end
      slave_done = 3'b100;
      tick();
      slave_done = 3'b000;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_write_id1();
      test_read_wrong_slave();
      test_unmapped();
      test_illegal_and_busy();
      test_timeout();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
